// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a SPR_W x SPR_H sprite ROM and drives the VGA plot port at a run-time origin.
// Optional build macro SPRITE_COLOR_KEY_EN suppresses plots of pixels whose colour equals KEY_COLOR.
module sprite_blitter #(
    parameter int SPR_W         = 16,
    parameter int SPR_H         = 16,
    parameter int WIDTH_X       = 8,
    parameter int WIDTH_Y       = 7,
    parameter int RESOLUTION_X  = 160,
    parameter int RESOLUTION_Y  = 120,
    parameter int COLOR_W       = 3,
    parameter int WIDTH_ADDRESS = $clog2(SPR_W * SPR_H),
    parameter int KEY_COLOR     = 0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [WIDTH_X-1:0]       org_x,
    input  logic [WIDTH_Y-1:0]       org_y,
    input  logic                     flip_x,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH_ADDRESS-1:0] rom_addr,
    input  logic [COLOR_W-1:0]       rom_q,
    output logic [WIDTH_X-1:0]       vga_x,
    output logic [WIDTH_Y-1:0]       vga_y,
    output logic [COLOR_W-1:0]       vga_colour,
    output logic                     vga_plot,
    output logic [2:0]               dbg_state
);

    localparam int CX_W = $clog2(SPR_W);
    localparam int CY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_FLUSH0 = 3'd2,
        S_FLUSH1 = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [CX_W-1:0]   cx, cx_nxt;
    logic [CY_W-1:0]   cy, cy_nxt;
    logic              load;
    logic [WIDTH_X-1:0] org_x_q;
    logic [WIDTH_Y-1:0] org_y_q;
    logic              flip_q;

    logic              cx_last, cy_last;
    logic [CX_W-1:0]   sx;
    logic [WIDTH_X:0]  sum_x;
    logic [WIDTH_Y:0]  sum_y;
    logic              in_bounds;
    logic              key_pass;

    logic               s1_valid;
    logic               s1_in;
    logic [WIDTH_X-1:0] s1_x;
    logic [WIDTH_Y-1:0] s1_y;

    assign cx_last   = (cx == CX_W'(SPR_W - 1));
    assign cy_last   = (cy == CY_W'(SPR_H - 1));
    assign dbg_state = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            cx      <= '0;
            cy      <= '0;
            org_x_q <= '0;
            org_y_q <= '0;
            flip_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cx    <= cx_nxt;
            cy    <= cy_nxt;
            if (load) begin
                org_x_q <= org_x;
                org_y_q <= org_y;
                flip_q  <= flip_x;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cx_nxt    = cx;
        cy_nxt    = cy;
        load      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    cx_nxt    = '0;
                    cy_nxt    = '0;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cx_last) begin
                    cx_nxt = '0;
                    if (cy_last) begin
                        cy_nxt    = '0;
                        state_nxt = S_FLUSH0;
                    end else begin
                        cy_nxt = cy + 1'b1;
                    end
                end else begin
                    cx_nxt = cx + 1'b1;
                end
            end
            S_FLUSH0: begin
                busy      = 1'b1;
                state_nxt = S_FLUSH1;
            end
            S_FLUSH1: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address is forced to 0 outside RUN so a stale flip cannot leak onto the ROM bus.
    assign sx       = flip_q ? (CX_W'(SPR_W - 1) - cx) : cx;
    assign rom_addr = (state == S_RUN)
                    ? (WIDTH_ADDRESS'(sx) + WIDTH_ADDRESS'(cy) * WIDTH_ADDRESS'(SPR_W))
                    : '0;

    // One extra bit keeps the screen sum from wrapping back onto the visible area.
    assign sum_x     = {1'b0, org_x_q} + (WIDTH_X + 1)'(cx);
    assign sum_y     = {1'b0, org_y_q} + (WIDTH_Y + 1)'(cy);
    assign in_bounds = (sum_x < (WIDTH_X + 1)'(RESOLUTION_X)) &&
                       (sum_y < (WIDTH_Y + 1)'(RESOLUTION_Y));

`ifdef SPRITE_COLOR_KEY_EN
    assign key_pass = (rom_q != COLOR_W'(KEY_COLOR));
`else
    assign key_pass = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_in    <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= (state == S_RUN);
            s1_in    <= in_bounds;
            s1_x     <= sum_x[WIDTH_X-1:0];
            s1_y     <= sum_y[WIDTH_Y-1:0];
        end
    end

    // Stage 2 meets the ROM data, which arrives one cycle after its address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else if (s1_valid) begin
            vga_x      <= s1_x;
            vga_y      <= s1_y;
            vga_colour <= rom_q;
            vga_plot   <= s1_in & key_pass;
        end else begin
            vga_plot   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a 4x2 sprite; bench ROM returns its own address as colour.
module tb_sprite_blitter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] org_x;
    logic [6:0] org_y;
    logic       flip_x;
    logic       busy;
    logic       done;
    logic [2:0] rom_addr;
    logic [2:0] rom_q;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic [2:0] dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic       cap_plot [32];
    logic       cap_busy [32];
    logic       cap_done [32];
    logic [7:0] cap_x    [32];
    logic [6:0] cap_y    [32];
    logic [2:0] cap_col  [32];

    sprite_blitter #(
        .SPR_W(4), .SPR_H(2), .WIDTH_X(8), .WIDTH_Y(7),
        .RESOLUTION_X(160), .RESOLUTION_Y(120), .COLOR_W(3), .KEY_COLOR(5)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .org_x(org_x), .org_y(org_y), .flip_x(flip_x),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_q(rom_q),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom_addr;

    task automatic launch(input logic [7:0] x, input logic [6:0] y, input logic f, input logic keep);
        @(negedge clk);
        org_x  = x;
        org_y  = y;
        flip_x = f;
        start  = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) start = 1'b0;
    endtask

    // Sample cycles 1..n after the accepting edge; optionally pulse start in one cycle.
    task automatic capture(input int n, input int pulse_at);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            cap_plot[c] = vga_plot;
            cap_busy[c] = busy;
            cap_done[c] = done;
            cap_x[c]    = vga_x;
            cap_y[c]    = vga_y;
            cap_col[c]  = vga_colour;
            if (pulse_at > 0 && c == pulse_at) start = 1'b1;
            else if (pulse_at > 0 && c == pulse_at + 1) start = 1'b0;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        org_x  = '0;
        org_y  = '0;
        flip_x = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, vga_plot} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl got busy/done/plot=%b want 000", {busy, done, vga_plot});
        end
        n_cmp++;
        if ({vga_x, vga_y, vga_colour, rom_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got x=%0d y=%0d col=%0d addr=%0d want all 0", vga_x, vga_y, vga_colour, rom_addr);
        end
        n_cmp++;
        if (dbg_state !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_state got %0d want 0", dbg_state);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic       ep;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        int         p;
        launch(8'd10, 7'd20, 1'b0, 1'b0);
        capture(12, 0);
        for (int c = 1; c <= 12; c++) begin
            p  = c - 3;
            ep = (c >= 3 && c <= 10);
            n_cmp++;
            if (cap_plot[c] !== ep) begin
                n_bad++;
                $display("FAIL basic_plot c=%0d got %0b want %0b", c, cap_plot[c], ep);
            end
            n_cmp++;
            if (cap_busy[c] !== (c <= 10)) begin
                n_bad++;
                $display("FAIL basic_busy c=%0d got %0b want %0b", c, cap_busy[c], (c <= 10));
            end
            n_cmp++;
            if (cap_done[c] !== (c == 11)) begin
                n_bad++;
                $display("FAIL basic_done c=%0d got %0b want %0b", c, cap_done[c], (c == 11));
            end
            if (ep) begin
                ex = 8'(10 + p % 4);
                ey = 7'(20 + p / 4);
                ec = 3'(p);
                n_cmp++;
                if ({cap_x[c], cap_y[c], cap_col[c]} !== {ex, ey, ec}) begin
                    n_bad++;
                    $display("FAIL basic_pixel c=%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                             c, cap_x[c], cap_y[c], cap_col[c], ex, ey, ec);
                end
            end
        end
    endtask

    task automatic test_mirror();
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        int         p;
        launch(8'd10, 7'd20, 1'b1, 1'b0);
        capture(12, 0);
        for (int c = 3; c <= 10; c++) begin
            p  = c - 3;
            ex = 8'(10 + p % 4);
            ey = 7'(20 + p / 4);
            ec = 3'((p / 4) * 4 + 3 - p % 4);
            n_cmp++;
            if ({cap_plot[c], cap_x[c], cap_y[c], cap_col[c]} !== {1'b1, ex, ey, ec}) begin
                n_bad++;
                $display("FAIL mirror_pixel c=%0d got plot=%0b (%0d,%0d,%0d) want plot=1 (%0d,%0d,%0d)",
                         c, cap_plot[c], cap_x[c], cap_y[c], cap_col[c], ex, ey, ec);
            end
        end
        n_cmp++;
        if ({cap_done[10], cap_done[11], cap_done[12]} !== 3'b010) begin
            n_bad++;
            $display("FAIL mirror_done got c10..12=%b want 010", {cap_done[10], cap_done[11], cap_done[12]});
        end
    endtask

    task automatic test_clip();
        logic ep;
        launch(8'd158, 7'd119, 1'b0, 1'b0);
        capture(12, 0);
        for (int c = 1; c <= 12; c++) begin
            ep = (c == 3 || c == 4);
            n_cmp++;
            if (cap_plot[c] !== ep) begin
                n_bad++;
                $display("FAIL clip_plot c=%0d got %0b want %0b", c, cap_plot[c], ep);
            end
        end
        n_cmp++;
        if ({cap_x[3], cap_y[3], cap_col[3]} !== {8'd158, 7'd119, 3'd0}) begin
            n_bad++;
            $display("FAIL clip_first got (%0d,%0d,%0d) want (158,119,0)", cap_x[3], cap_y[3], cap_col[3]);
        end
        n_cmp++;
        if ({cap_x[4], cap_y[4], cap_col[4]} !== {8'd159, 7'd119, 3'd1}) begin
            n_bad++;
            $display("FAIL clip_second got (%0d,%0d,%0d) want (159,119,1)", cap_x[4], cap_y[4], cap_col[4]);
        end
        n_cmp++;
        if ({cap_x[10], cap_y[10], cap_col[10]} !== {8'd161, 7'd120, 3'd7}) begin
            n_bad++;
            $display("FAIL clip_trunc got (%0d,%0d,%0d) want (161,120,7)", cap_x[10], cap_y[10], cap_col[10]);
        end
        n_cmp++;
        if ({cap_done[10], cap_done[11], cap_done[12]} !== 3'b010) begin
            n_bad++;
            $display("FAIL clip_done got c10..12=%b want 010", {cap_done[10], cap_done[11], cap_done[12]});
        end
    endtask

    task automatic test_start_ignored();
        int plots;
        int dones;
        launch(8'd10, 7'd20, 1'b0, 1'b0);
        capture(16, 5);
        plots = 0;
        dones = 0;
        for (int c = 1; c <= 16; c++) begin
            if (cap_plot[c] === 1'b1) plots++;
            if (cap_done[c] === 1'b1) dones++;
        end
        n_cmp++;
        if (plots != 8) begin
            n_bad++;
            $display("FAIL ignore_plots got %0d want 8", plots);
        end
        n_cmp++;
        if (dones != 1 || cap_done[11] !== 1'b1) begin
            n_bad++;
            $display("FAIL ignore_done got count=%0d c11=%0b want count=1 c11=1", dones, cap_done[11]);
        end
    endtask

    task automatic test_back_to_back();
        int plots;
        launch(8'd10, 7'd20, 1'b0, 1'b1);
        capture(23, 0);
        start = 1'b0;
        plots = 0;
        for (int c = 1; c <= 23; c++) begin
            if (cap_plot[c] === 1'b1) plots++;
            n_cmp++;
            if (cap_done[c] !== (c == 11 || c == 23)) begin
                n_bad++;
                $display("FAIL b2b_done c=%0d got %0b want %0b", c, cap_done[c], (c == 11 || c == 23));
            end
        end
        n_cmp++;
        if (plots != 16) begin
            n_bad++;
            $display("FAIL b2b_plots got %0d want 16", plots);
        end
        n_cmp++;
        if ({cap_busy[12], cap_busy[13], cap_busy[22]} !== 3'b011) begin
            n_bad++;
            $display("FAIL b2b_busy got c12,c13,c22=%b want 011", {cap_busy[12], cap_busy[13], cap_busy[22]});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle got busy=%0b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_job();
        int late;
        launch(8'd10, 7'd20, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, vga_plot, vga_x, vga_y, vga_colour, rom_addr} !== '0) begin
            n_bad++;
            $display("FAIL midreset_out got busy=%0b done=%0b plot=%0b x=%0d y=%0d col=%0d addr=%0d want all 0",
                     busy, done, vga_plot, vga_x, vga_y, vga_colour, rom_addr);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        late = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1 || vga_plot === 1'b1 || busy === 1'b1) late++;
        end
        n_cmp++;
        if (late != 0) begin
            n_bad++;
            $display("FAIL midreset_quiet got %0d active cycles want 0", late);
        end
        test_basic();
    endtask

    task automatic test_color_key();
        int   plots;
        logic want_slot;
        int   want_plots;
`ifdef SPRITE_COLOR_KEY_EN
        want_slot  = 1'b0;
        want_plots = 7;
`else
        want_slot  = 1'b1;
        want_plots = 8;
`endif
        launch(8'd10, 7'd20, 1'b0, 1'b0);
        capture(12, 0);
        plots = 0;
        for (int c = 1; c <= 12; c++) if (cap_plot[c] === 1'b1) plots++;
        n_cmp++;
        if (plots != want_plots) begin
            n_bad++;
            $display("FAIL key_plots got %0d want %0d", plots, want_plots);
        end
        n_cmp++;
        if ({cap_plot[8], cap_x[8], cap_y[8], cap_col[8]} !== {want_slot, 8'd11, 7'd21, 3'd5}) begin
            n_bad++;
            $display("FAIL key_slot got plot=%0b (%0d,%0d,%0d) want plot=%0b (11,21,5)",
                     cap_plot[8], cap_x[8], cap_y[8], cap_col[8], want_slot);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mirror();
        test_clip();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_job();
        test_color_key();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
